// File: rtl/token_link_arbiter.sv
// token_link_arbiter
// Round-robin owner selection for one shared downstream token link.
// A requester holds I_Acq until granted, streams I_Valid/I_Data while it owns
// the link and ends the session with a one-cycle I_Rls pulse.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after TIMEOUT idle
// owner cycles in gRANT). Without it a session ends only by I_Rls or reset.
//
// Token handshake: a word moves downstream on a cycle where the owner drives
// I_Valid and I_Nack is low; O_Valid/O_Data present it one cycle later.
// If I_Nack is high when the owner drives I_Valid, the word is kept in O_Data
// (sTALL) and re-presented exactly once with O_Valid=1 after I_Nack falls.
// Upstream O_Nack is 1 for every non-owner; the owner sees the registered
// I_Nack, forced to 1 while a word is held.
module token_link_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_ID   = $clog2(NUM_REQ),
   parameter int TIMEOUT    = 64
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            I_Acq,
   input  logic [NUM_REQ-1:0]            I_Rls,
   input  logic [NUM_REQ-1:0]            I_Valid,
   input  logic [NUM_REQ*WIDTH_DATA-1:0] I_Data,
   output logic [NUM_REQ-1:0]            O_Nack,
   output logic [NUM_REQ-1:0]            O_Grant,
   output logic                          O_Valid,
   output logic [WIDTH_DATA-1:0]         O_Data,
   output logic                          O_We,
   output logic [WIDTH_ID-1:0]           O_Owner,
   input  logic                          I_Nack,
   output logic [1:0]                    O_State
);

   typedef enum logic [1:0] {
      iDLE    = 2'd0,
      gRANT   = 2'd1,
      sTALL   = 2'd2,
      rELEASE = 2'd3
   } state_t;

   state_t                r_fsm;
   state_t                w_fsm_nxt;
   logic [WIDTH_ID-1:0]   r_owner;
   logic [WIDTH_ID-1:0]   w_owner_nxt;
   logic [WIDTH_ID-1:0]   r_ptr;
   logic [WIDTH_ID-1:0]   w_ptr_nxt;
   logic [NUM_REQ-1:0]    r_grant;
   logic [NUM_REQ-1:0]    w_grant_nxt;
   logic                  r_valid;
   logic                  w_valid_nxt;
   logic [WIDTH_DATA-1:0] r_data;
   logic [WIDTH_DATA-1:0] w_data_nxt;
   logic                  r_rls_pend;
   logic                  w_pend_nxt;
   logic                  r_nack;

   // owner lane selection
   logic                  w_own_valid;
   logic                  w_own_rls;
   logic [WIDTH_DATA-1:0] w_own_data;

   // arbitration
   logic [NUM_REQ-1:0]    w_rot;
   logic                  w_any;
   logic [WIDTH_ID-1:0]   w_off;
   logic [WIDTH_ID:0]     w_sum;
   logic [WIDTH_ID-1:0]   w_win;
   logic [NUM_REQ-1:0]    w_win_oh;
   logic [WIDTH_ID-1:0]   w_owner_inc;

   logic                  w_timeout;

   // Pick the current owner's valid, release and data lanes.
   always_comb begin
      w_own_valid = 1'b0;
      w_own_rls   = 1'b0;
      w_own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_owner == WIDTH_ID'(i)) begin
            w_own_valid = I_Valid[i];
            w_own_rls   = I_Rls[i];
            w_own_data  = I_Data[i*WIDTH_DATA +: WIDTH_DATA];
         end
      end
   end

   // Requests rotated so bit k is requester (r_ptr + k) mod NUM_REQ.
   assign w_rot = NUM_REQ'({I_Acq, I_Acq} >> r_ptr);
   assign w_any = |w_rot;

   // Lowest set bit of the rotated vector is the first requester at or above r_ptr.
   always_comb begin
      w_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = WIDTH_ID'(k);
         end
      end
   end

   assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_win    = (w_sum >= (WIDTH_ID+1)'(NUM_REQ)) ?
                     WIDTH_ID'(w_sum - (WIDTH_ID+1)'(NUM_REQ)) : w_sum[WIDTH_ID-1:0];
   assign w_win_oh = NUM_REQ'(1) << w_win;

   // Pointer moves past the releasing owner so it goes last next round.
   assign w_owner_inc = (r_owner == WIDTH_ID'(NUM_REQ - 1)) ? '0 : r_owner + WIDTH_ID'(1);

`ifdef ARB_TIMEOUT_EN
   localparam int WIDTH_CNT = $clog2(TIMEOUT + 1);
   logic [WIDTH_CNT-1:0] r_cnt;

   assign w_timeout = (r_fsm == gRANT) && (r_cnt == WIDTH_CNT'(TIMEOUT));

   // Idle-owner counter: counts silent gRANT cycles, frozen while a word is held.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else begin
         case (r_fsm)
            gRANT: begin
               if (w_own_valid) begin
                  r_cnt <= '0;
               end else if (!w_timeout) begin
                  r_cnt <= r_cnt + WIDTH_CNT'(1);
               end
            end
            sTALL:   r_cnt <= r_cnt;
            default: r_cnt <= '0;
         endcase
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fsm <= iDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // Next state plus next values of owner, pointer and the downstream registers.
   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_grant_nxt = r_grant;
      w_valid_nxt = 1'b0;
      w_data_nxt  = r_data;
      w_pend_nxt  = r_rls_pend;
      case (r_fsm)
         iDLE: begin
            w_grant_nxt = '0;
            if (w_any) begin
               w_fsm_nxt   = gRANT;
               w_owner_nxt = w_win;
               w_grant_nxt = w_win_oh;
            end
         end
         gRANT: begin
            w_valid_nxt = w_own_valid & ~I_Nack;
            if (w_own_valid) begin
               w_data_nxt = w_own_data;
            end
            if (w_own_valid && I_Nack) begin
               // Word is held; a release arriving with it waits for the drain.
               w_fsm_nxt = sTALL;
               if (w_own_rls) begin
                  w_pend_nxt = 1'b1;
               end
            end else if (w_own_rls || r_rls_pend || w_timeout) begin
               w_fsm_nxt   = rELEASE;
               w_grant_nxt = '0;
               w_pend_nxt  = 1'b0;
            end
         end
         sTALL: begin
            if (w_own_rls) begin
               w_pend_nxt = 1'b1;
            end
            if (!I_Nack) begin
               w_fsm_nxt   = gRANT;
               w_valid_nxt = 1'b1;
            end
         end
         rELEASE: begin
            w_fsm_nxt   = iDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = w_owner_inc;
            w_pend_nxt  = 1'b0;
         end
         default: begin
            w_fsm_nxt   = iDLE;
            w_grant_nxt = '0;
            w_pend_nxt  = 1'b0;
         end
      endcase
   end

   // Owner, pointer, grant and downstream token registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_owner    <= '0;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_rls_pend <= 1'b0;
         r_nack     <= 1'b0;
      end else begin
         r_owner    <= w_owner_nxt;
         r_ptr      <= w_ptr_nxt;
         r_grant    <= w_grant_nxt;
         r_valid    <= w_valid_nxt;
         r_data     <= w_data_nxt;
         r_rls_pend <= w_pend_nxt;
         r_nack     <= I_Nack;
      end
   end

   // Upstream nack: all ones unless in gRANT, where the owner sees the registered I_Nack.
   always_comb begin
      O_Nack = '1;
      if (r_fsm == gRANT) begin
         O_Nack = ~r_grant | {NUM_REQ{r_nack}};
      end
   end

   assign O_Grant = r_grant;
   assign O_Valid = r_valid;
   assign O_We    = r_valid;
   assign O_Data  = r_data;
   assign O_Owner = r_owner;
   assign O_State = r_fsm;

endmodule

// File: tb/tb_token_link_arbiter.sv
// tb_token_link_arbiter
// Cycle vectors for token_link_arbiter (NUM_REQ=4, WIDTH_DATA=32, TIMEOUT=8).
// Requester lane i carries dval + i*0x1000_0000 so a wrong lane shows up in O_Data.
// State encoding on O_State: 0 iDLE, 1 gRANT, 2 sTALL, 3 rELEASE.
module tb_token_link_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NREQ-1:0]   I_Acq = '0;
  logic [NREQ-1:0]   I_Rls = '0;
  logic [NREQ-1:0]   I_Valid = '0;
  logic [NREQ*W-1:0] I_Data = '0;
  logic              I_Nack = 1'b0;
  logic [NREQ-1:0]   O_Nack;
  logic [NREQ-1:0]   O_Grant;
  logic              O_Valid;
  logic [W-1:0]      O_Data;
  logic              O_We;
  logic [1:0]        O_Owner;
  logic [1:0]        O_State;

  token_link_arbiter #(
    .NUM_REQ(NREQ), .WIDTH_DATA(W), .WIDTH_ID(2), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .I_Acq(I_Acq), .I_Rls(I_Rls), .I_Valid(I_Valid), .I_Data(I_Data),
    .O_Nack(O_Nack), .O_Grant(O_Grant), .O_Valid(O_Valid), .O_Data(O_Data),
    .O_We(O_We), .O_Owner(O_Owner), .I_Nack(I_Nack), .O_State(O_State)
  );

  typedef struct {
    logic [3:0]  acq;
    logic [3:0]  rls;
    logic [3:0]  vld;
    logic [31:0] dval;
    logic        nk;
    logic [1:0]  st;
    logic [3:0]  grant;
    logic [1:0]  own;
    logic        ov;
    logic [31:0] od;
    logic [3:0]  onack;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mkv(logic [3:0] acq, logic [3:0] rls, logic [3:0] vld,
                               logic [31:0] dval, logic nk, logic [1:0] st,
                               logic [3:0] grant, logic [1:0] own, logic ov,
                               logic [31:0] od, logic [3:0] onack);
    vec_t v;
    v.acq = acq; v.rls = rls; v.vld = vld; v.dval = dval; v.nk = nk;
    v.st = st; v.grant = grant; v.own = own; v.ov = ov; v.od = od; v.onack = onack;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] acq, input logic [3:0] rls, input logic [3:0] vld,
                       input logic [31:0] dval, input logic nk);
    I_Acq   = acq;
    I_Rls   = rls;
    I_Valid = vld;
    I_Nack  = nk;
    for (int i = 0; i < NREQ; i++) I_Data[i*W +: W] = dval + (32'(i) << 28);
  endtask

  task automatic chk_outputs(input int row, input vec_t v);
    chk("state", row, 32'(O_State), 32'(v.st));
    chk("grant", row, 32'(O_Grant), 32'(v.grant));
    chk("owner", row, 32'(O_Owner), 32'(v.own));
    chk("valid", row, 32'(O_Valid), 32'(v.ov));
    chk("we",    row, 32'(O_We),    32'(v.ov));
    chk("data",  row, O_Data,       v.od);
    chk("nack",  row, 32'(O_Nack),  32'(v.onack));
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   n_edges;
    bit   seen;

    // ---- reset state ----
    drive(4'h0, 4'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    rv = mkv(4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 32'h0, 4'hF);
    chk_outputs(-1, rv);
    @(negedge clock);
    reset = 1'b1;

    // ---- vector table: inputs for one cycle -> registered outputs after it ----
    //                 acq   rls   vld   dval           nk    st    grant own  ov    od              onack
    vq.push_back(mkv(4'h0, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 32'h0,        4'hF)); // 0 idle
    vq.push_back(mkv(4'h0, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 32'h0,        4'hF)); // 1
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h1, 2'd0, 1'b0, 32'h0,        4'hE)); // 2 grant 0
    vq.push_back(mkv(4'h5, 4'h0, 4'h1, 32'hA,        1'b0, 2'd1, 4'h1, 2'd0, 1'b1, 32'hA,        4'hE)); // 3 A
    vq.push_back(mkv(4'h5, 4'h4, 4'h1, 32'hB,        1'b0, 2'd1, 4'h1, 2'd0, 1'b1, 32'hB,        4'hE)); // 4 B, non-owner rls
    vq.push_back(mkv(4'h5, 4'h0, 4'h1, 32'hC,        1'b0, 2'd1, 4'h1, 2'd0, 1'b1, 32'hC,        4'hE)); // 5 C
    vq.push_back(mkv(4'h5, 4'h1, 4'h0, 32'h0,        1'b0, 2'd3, 4'h0, 2'd0, 1'b0, 32'hC,        4'hF)); // 6 release
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 32'hC,        4'hF)); // 7 idle bubble
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h4, 2'd2, 1'b0, 32'hC,        4'hB)); // 8 grant 2
    vq.push_back(mkv(4'h5, 4'h0, 4'h4, 32'h55,       1'b1, 2'd2, 4'h4, 2'd2, 1'b0, 32'h2000_0055, 4'hF)); // 9 stall 1
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b1, 2'd2, 4'h4, 2'd2, 1'b0, 32'h2000_0055, 4'hF)); // 10 stall 2
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b1, 2'd2, 4'h4, 2'd2, 1'b0, 32'h2000_0055, 4'hF)); // 11 stall 3
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b1, 2'd2, 4'h4, 2'd2, 1'b0, 32'h2000_0055, 4'hF)); // 12 stall 4
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h4, 2'd2, 1'b1, 32'h2000_0055, 4'hB)); // 13 drain once
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h4, 2'd2, 1'b0, 32'h2000_0055, 4'hB)); // 14 no duplicate
    vq.push_back(mkv(4'h5, 4'h4, 4'h0, 32'h0,        1'b0, 2'd3, 4'h0, 2'd2, 1'b0, 32'h2000_0055, 4'hF)); // 15 release
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd2, 1'b0, 32'h2000_0055, 4'hF)); // 16
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h8, 2'd3, 1'b0, 32'h2000_0055, 4'h7)); // 17 grant 3
    vq.push_back(mkv(4'hF, 4'h8, 4'h8, 32'h11,       1'b0, 2'd3, 4'h0, 2'd3, 1'b1, 32'h3000_0011, 4'hF)); // 18 valid+rls
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd3, 1'b0, 32'h3000_0011, 4'hF)); // 19
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h1, 2'd0, 1'b0, 32'h3000_0011, 4'hE)); // 20 grant 0
    vq.push_back(mkv(4'hF, 4'h1, 4'h1, 32'h22,       1'b0, 2'd3, 4'h0, 2'd0, 1'b1, 32'h22,        4'hF)); // 21
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 32'h22,        4'hF)); // 22
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h2, 2'd1, 1'b0, 32'h22,        4'hD)); // 23 grant 1
    vq.push_back(mkv(4'hF, 4'h2, 4'h2, 32'h33,       1'b0, 2'd3, 4'h0, 2'd1, 1'b1, 32'h1000_0033, 4'hF)); // 24
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd1, 1'b0, 32'h1000_0033, 4'hF)); // 25
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h4, 2'd2, 1'b0, 32'h1000_0033, 4'hB)); // 26 grant 2
    vq.push_back(mkv(4'hF, 4'h4, 4'h4, 32'h44,       1'b0, 2'd3, 4'h0, 2'd2, 1'b1, 32'h2000_0044, 4'hF)); // 27
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd2, 1'b0, 32'h2000_0044, 4'hF)); // 28
    vq.push_back(mkv(4'hF, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h8, 2'd3, 1'b0, 32'h2000_0044, 4'h7)); // 29 grant 3 again
    vq.push_back(mkv(4'h2, 4'h8, 4'h0, 32'h0,        1'b0, 2'd3, 4'h0, 2'd3, 1'b0, 32'h2000_0044, 4'hF)); // 30
    vq.push_back(mkv(4'h2, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd3, 1'b0, 32'h2000_0044, 4'hF)); // 31
    vq.push_back(mkv(4'h2, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h2, 2'd1, 1'b0, 32'h2000_0044, 4'hD)); // 32 grant 1
    vq.push_back(mkv(4'h5, 4'h0, 4'h2, 32'h77,       1'b1, 2'd2, 4'h2, 2'd1, 1'b0, 32'h1000_0077, 4'hF)); // 33 stall
    vq.push_back(mkv(4'h5, 4'h2, 4'h0, 32'h0,        1'b1, 2'd2, 4'h2, 2'd1, 1'b0, 32'h1000_0077, 4'hF)); // 34 rls in stall
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h2, 2'd1, 1'b1, 32'h1000_0077, 4'hD)); // 35 drain
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd3, 4'h0, 2'd1, 1'b0, 32'h1000_0077, 4'hF)); // 36 deferred release
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd0, 4'h0, 2'd1, 1'b0, 32'h1000_0077, 4'hF)); // 37
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h4, 2'd2, 1'b0, 32'h1000_0077, 4'hB)); // 38 grant 2
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b1, 2'd1, 4'h4, 2'd2, 1'b0, 32'h1000_0077, 4'hF)); // 39 nack passthrough
    vq.push_back(mkv(4'h5, 4'h0, 4'h0, 32'h0,        1'b0, 2'd1, 4'h4, 2'd2, 1'b0, 32'h1000_0077, 4'hB)); // 40

    for (int r = 0; r < vq.size(); r++) begin
      @(negedge clock);
      drive(vq[r].acq, vq[r].rls, vq[r].vld, vq[r].dval, vq[r].nk);
      @(posedge clock);
      #1;
      chk_outputs(r, vq[r]);
    end

    // ---- reset asserted mid-session with a word in flight ----
    @(negedge clock);
    drive(4'h0, 4'h0, 4'h4, 32'h99, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    rv = mkv(4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 32'h0, 4'hF);
    chk_outputs(100, rv);
    @(posedge clock);
    #1;
    chk("rst_drop_valid", 101, 32'(O_Valid), 32'h0);
    chk("rst_drop_data",  101, O_Data,       32'h0);
    @(negedge clock);
    drive(4'h0, 4'h0, 4'h0, 32'h0, 1'b0);
    reset = 1'b1;

    // ---- idle owner: forced release or indefinite hold ----
    @(negedge clock);
    drive(4'h8, 4'h0, 4'h0, 32'h0, 1'b0);
    @(posedge clock);
    #1;
    chk("idle_grant3", 102, 32'(O_Grant), 32'h8);
    chk("idle_state",  102, 32'(O_State), 32'd1);
    @(negedge clock);
    drive(4'h9, 4'h0, 4'h0, 32'h0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    n_edges = 0;
    seen    = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clock);
      #1;
      if (O_State == 2'd3) begin
        seen    = 1'b1;
        n_edges = i;
      end
    end
    chk("timeout_edges", 103, 32'(n_edges), 32'd9);
    chk("timeout_grant", 103, 32'(O_Grant), 32'h0);
    @(posedge clock);
    #1;
    chk("timeout_idle",  104, 32'(O_State), 32'd0);
    @(posedge clock);
    #1;
    chk("timeout_next_grant", 105, 32'(O_Grant), 32'h1);
    chk("timeout_next_owner", 105, 32'(O_Owner), 32'h0);
`else
    n_edges = 80;
    seen    = 1'b0;
    repeat (n_edges) @(posedge clock);
    #1;
    chk("hold_state", 103, 32'(O_State), 32'd1);
    chk("hold_grant", 103, 32'(O_Grant), 32'h8);
    chk("hold_owner", 103, 32'(O_Owner), 32'h3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
